// File: rtl/ahb_blockram_ctrl.sv
// AHB-Lite slave front end for a simple dual-port block RAM.
// Zero-wait reads and writes, read-after-write forwarding, two-cycle ERROR.
module ahb_blockram_ctrl #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic                  HWRITE,
   input  logic                  HREADY,
   input  logic [31:0]           HWDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [31:0]           HRDATA,
   output logic [ADDR_WIDTH-1:0] addra,
   output logic [31:0]           dina,
   output logic [3:0]            wea,
   output logic [ADDR_WIDTH-1:0] addrb,
   input  logic [31:0]           doutb
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic                    w_accept;
   logic                    w_legal;
   logic                    w_go;
   logic [3:0]              w_mask;
   logic [ADDR_WIDTH-1:0]   w_waddr;
   logic                    r_wr_pend;
   logic [ADDR_WIDTH-1:0]   r_wr_addr;
   logic [3:0]              r_wr_mask;
   logic [3:0]              r_fwd_mask;
   logic [31:0]             r_fwd_data;

   assign w_accept = HSEL & HTRANS[1] & HREADY;
   assign w_waddr  = HADDR[ADDR_WIDTH+1:2];
   // No address phase can complete while the first ERROR cycle stalls the bus
   assign w_go     = w_accept & w_legal & (r_state != S_ERR1);

   always_comb begin
      w_legal = 1'b0;
      w_mask  = 4'b0000;
      unique case (HSIZE)
         3'd0: begin
            w_legal = 1'b1;
            w_mask  = 4'b0001 << HADDR[1:0];
         end
         3'd1: begin
            w_legal = ~HADDR[0];
            w_mask  = 4'b0011 << HADDR[1:0];
         end
         3'd2: begin
            w_legal = (HADDR[1:0] == 2'b00);
            w_mask  = 4'b1111;
         end
         default: begin
            w_legal = 1'b0;
            w_mask  = 4'b0000;
         end
      endcase
   end

   always_comb begin
      w_next    = r_state;
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept && !w_legal) w_next = S_ERR1;
         end
         S_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
            w_next    = S_ERR2;
         end
         S_ERR2: begin
            HRESP  = 1'b1;
            w_next = (w_accept && !w_legal) ? S_ERR1 : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_state    <= S_IDLE;
         r_wr_pend  <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_mask  <= 4'b0000;
         r_fwd_mask <= 4'b0000;
         r_fwd_data <= 32'h0;
      end else begin
         r_state    <= w_next;
         r_wr_pend  <= w_go & HWRITE;
         r_wr_addr  <= w_waddr;
         r_wr_mask  <= w_mask;
         r_fwd_data <= HWDATA;
         // RAM is read-first, so a read meeting a write to its word misses it
         if (w_go && !HWRITE && r_wr_pend && (r_wr_addr == w_waddr))
            r_fwd_mask <= r_wr_mask;
         else
            r_fwd_mask <= 4'b0000;
      end
   end

   assign addra = r_wr_addr;
   assign dina  = HWDATA;
   assign wea   = (r_wr_pend && HRESETn) ? r_wr_mask : 4'b0000;
   assign addrb = w_waddr;

   always_comb begin
      HRDATA = doutb;
      for (int i = 0; i < 4; i++) begin
         if (r_fwd_mask[i]) HRDATA[8*i +: 8] = r_fwd_data[8*i +: 8];
      end
   end

endmodule
